// File: rtl/uart_rx_os.sv
// Oversampling UART receiver.
// Recovers LSB-first frames from the asynchronous rx pin. Each bit is decided
// by a 3-sample majority vote around mid-bit, and the start bit is re-checked
// at its own mid-bit so that short glitches are rejected. Received bytes are
// offered on a valid/ready handshake. Framing and overrun errors are reported
// as single-cycle pulses.
module uart_rx_os #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W    = $clog2(OVERSAMPLE);
  localparam int BIT_W   = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_SAMP0  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_SAMP1  = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]  OS_DECIDE = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t                 state;
  logic                   rx_s1;
  logic                   rxs;
  logic [DIV_W-1:0]       div_cnt;
  logic                   tick;
  logic [OS_W-1:0]        os;
  logic [BIT_W-1:0]       bit_idx;
  logic                   samp0;
  logic                   samp1;
  logic                   vote;
  logic [DATA_BITS-1:0]   shreg;

  // 2-of-3 majority of the mid-bit samples.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // The third sample is the live value on the decide tick, so only two are stored.
  assign vote = maj3(samp0, samp1, rxs);
  assign tick = (div_cnt == DIV_LAST);
  assign busy = (state != IDLE);

  // Two-flop synchronizer; idles high so reset does not look like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rxs   <= rx_s1;
    end
  end

  // Oversample tick divider: parked at 0 while idle, so bit timing is anchored to the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (state == IDLE && rxs) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Frame state machine with sample capture, shift register and registered handshake/flag outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      os        <= '0;
      bit_idx   <= '0;
      samp0     <= 1'b0;
      samp1     <= 1'b0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (state != IDLE && tick) begin
        os <= (os == OS_LAST) ? '0 : os + 1'b1;
        if (os == OS_SAMP0) samp0 <= rxs;
        if (os == OS_SAMP1) samp1 <= rxs;
      end

      case (state)
        IDLE: begin
          if (!rxs) begin
            state   <= START;
            os      <= '0;
            bit_idx <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (os == OS_DECIDE && vote) begin
              state <= IDLE;
            end else if (os == OS_LAST) begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (os == OS_DECIDE) begin
              shreg <= {vote, shreg[DATA_BITS-1:1]};
            end
            if (os == OS_LAST) begin
              if (bit_idx == BIT_LAST) begin
                state   <= STOP;
                bit_idx <= '0;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
            end
          end
        end
        STOP: begin
          // Leave at mid-bit on both outcomes so a start bit right after the stop bit is seen.
          if (tick && os == OS_DECIDE) begin
            if (vote) begin
              state <= IDLE;
              if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end
        end
        BRK: begin
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: 32 MHz clock, 1 Mbaud, 16x oversampling
// (one bit = 32 clocks). A negedge monitor pops expected bytes from a queue on
// each delivery; scenario tasks check flags, busy and handshake inline.
module tb_uart_rx_os;

  localparam int BIT_CLKS = 32;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int del_count    = 0;
  int fe_count     = 0;
  int ov_count     = 0;

  logic [7:0] exp_q[$];
  logic       pv    = 1'b0;
  logic       pacc  = 1'b0;
  logic [7:0] pdata = 8'h00;

  uart_rx_os #(
    .CLK_FREQ  (32_000_000),
    .BAUD      (1_000_000),
    .OVERSAMPLE(16),
    .DATA_BITS (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: a delivery is rx_valid high after it was low or was just accepted.
  always @(negedge clk) begin
    logic [7:0] exp;
    if (!rst_n) begin
      pv   = 1'b0;
      pacc = 1'b0;
    end else begin
      if (rx_valid && (!pv || pacc)) begin
        del_count++;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_unexpected: rx_data=%h delivered, no byte expected", rx_data);
        end else begin
          exp = exp_q.pop_front();
          if (rx_data !== exp) begin
            tests_failed++;
            $display("FAIL sb_data: rx_data=%h, expected %h", rx_data, exp);
          end
        end
      end else if (rx_valid && pv && !pacc) begin
        tests_run++;
        if (rx_data !== pdata) begin
          tests_failed++;
          $display("FAIL hold_stable: rx_data=%h changed while held, expected %h", rx_data, pdata);
        end
      end
      if (frame_err === 1'b1) fe_count++;
      if (overrun === 1'b1) ov_count++;
      if (frame_err === 1'b1 && overrun === 1'b1) begin
        tests_run++;
        tests_failed++;
        $display("FAIL flags_together: frame_err=%b overrun=%b, expected not both", frame_err, overrun);
      end
      pv    = rx_valid;
      pacc  = rx_valid && rx_ready;
      pdata = rx_data;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Drives start, 8 data bits LSB first and a stop bit of stop_clks clocks at level stop_val.
  // spike_bit >= 0 inverts that data bit for one clock at its middle.
  task automatic send_frame(input logic [7:0] d, input logic stop_val, input int stop_clks,
                            input int spike_bit);
    logic [7:0] dv;
    dv = d;
    rx = 1'b0;
    cyc(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = dv[i];
      if (i == spike_bit) begin
        cyc(16);
        rx = ~dv[i];
        cyc(1);
        rx = dv[i];
        cyc(BIT_CLKS - 17);
      end else begin
        cyc(BIT_CLKS);
      end
    end
    rx = stop_val;
    cyc(stop_clks);
  endtask

  task automatic accept();
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
  endtask

  task automatic check_drained(input string name);
    tests_run++;
    if (exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL %s_drained: %0d bytes still expected, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rx       = 1'b1;
    rx_ready = 1'b0;
    rst_n    = 1'b0;
    cyc(4);
    tests_run++;
    if ({rx_valid, frame_err, overrun, busy} !== 4'b0000 || rx_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid=%b fe=%b ov=%b busy=%b data=%h, expected all 0",
               rx_valid, frame_err, overrun, busy, rx_data);
    end
    rst_n = 1'b1;
    cyc(4);
    tests_run++;
    if (busy !== 1'b0 || rx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: busy=%b valid=%b, expected 0 0", busy, rx_valid);
    end
  endtask

  task automatic test_basic();
    int fe0, ov0;
    fe0 = fe_count;
    ov0 = ov_count;
    rx_ready = 1'b0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, BIT_CLKS, -1);
    cyc(20);
    tests_run++;
    if (rx_valid !== 1'b1 || rx_data !== 8'hA5) begin
      tests_failed++;
      $display("FAIL basic_hold: valid=%b data=%h, expected 1 a5", rx_valid, rx_data);
    end
    accept();
    tests_run++;
    if (rx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_accept: valid=%b, expected 0", rx_valid);
    end
    tests_run++;
    if (fe_count !== fe0 || ov_count !== ov0) begin
      tests_failed++;
      $display("FAIL basic_flags: fe=%0d ov=%0d pulses, expected 0 0", fe_count - fe0, ov_count - ov0);
    end
    check_drained("basic");
  endtask

  task automatic test_glitch();
    int d0, fe0, ov0;
    d0  = del_count;
    fe0 = fe_count;
    ov0 = ov_count;
    rx_ready = 1'b1;
    rx = 1'b0;
    cyc(4);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL glitch_busy: busy=%b, expected 1", busy);
    end
    cyc(6);
    rx = 1'b1;
    cyc(40);
    tests_run++;
    if (busy !== 1'b0 || rx_valid !== 1'b0 || del_count !== d0 || fe_count !== fe0 || ov_count !== ov0) begin
      tests_failed++;
      $display("FAIL glitch_reject: busy=%b valid=%b deliveries=%0d flags=%0d, expected 0 0 0 0",
               busy, rx_valid, del_count - d0, (fe_count - fe0) + (ov_count - ov0));
    end
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, BIT_CLKS, -1);
    cyc(8);
    exp_q.push_back(8'h00);
    send_frame(8'h00, 1'b1, BIT_CLKS, 2);
    cyc(8);
    tests_run++;
    if (del_count - d0 !== 2) begin
      tests_failed++;
      $display("FAIL glitch_count: %0d deliveries, expected 2", del_count - d0);
    end
    check_drained("glitch");
  endtask

  task automatic test_framing();
    int d0, fe0;
    d0  = del_count;
    fe0 = fe_count;
    rx_ready = 1'b1;
    send_frame(8'h81, 1'b0, 5 * BIT_CLKS, -1);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL frame_busy_brk: busy=%b, expected 1", busy);
    end
    tests_run++;
    if (fe_count - fe0 !== 1 || rx_valid !== 1'b0 || del_count !== d0) begin
      tests_failed++;
      $display("FAIL frame_err_pulse: %0d pulses valid=%b deliveries=%0d, expected 1 0 0",
               fe_count - fe0, rx_valid, del_count - d0);
    end
    rx = 1'b1;
    cyc(4);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL frame_brk_exit: busy=%b, expected 0", busy);
    end
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, BIT_CLKS, -1);
    cyc(8);
    tests_run++;
    if (fe_count - fe0 !== 1) begin
      tests_failed++;
      $display("FAIL frame_after: %0d frame_err pulses, expected 1", fe_count - fe0);
    end
    check_drained("frame");
  endtask

  task automatic test_overrun();
    int ov0, fe0;
    ov0 = ov_count;
    fe0 = fe_count;
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, BIT_CLKS, -1);
    cyc(4);
    send_frame(8'h22, 1'b1, BIT_CLKS, -1);
    cyc(8);
    tests_run++;
    if (ov_count - ov0 !== 1 || fe_count !== fe0) begin
      tests_failed++;
      $display("FAIL overrun_pulse: %0d overrun %0d frame_err pulses, expected 1 0",
               ov_count - ov0, fe_count - fe0);
    end
    tests_run++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin
      tests_failed++;
      $display("FAIL overrun_keep: valid=%b data=%h, expected 1 11", rx_valid, rx_data);
    end
    accept();
    tests_run++;
    if (rx_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_accept: valid=%b, expected 0", rx_valid);
    end
    check_drained("overrun");
  endtask

  task automatic test_back_to_back();
    int d0, fe0, ov0;
    logic [7:0] pat [3];
    pat[0] = 8'h00;
    pat[1] = 8'hFF;
    pat[2] = 8'h55;
    d0  = del_count;
    fe0 = fe_count;
    ov0 = ov_count;
    rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pat[i]);
      send_frame(pat[i], 1'b1, BIT_CLKS, -1);
    end
    cyc(8);
    tests_run++;
    if (del_count - d0 !== 3 || fe_count !== fe0 || ov_count !== ov0) begin
      tests_failed++;
      $display("FAIL b2b_events: deliveries=%0d fe=%0d ov=%0d, expected 3 0 0",
               del_count - d0, fe_count - fe0, ov_count - ov0);
    end
    check_drained("b2b");
    rx_ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'hC3;
    rx_ready = 1'b0;
    rx = 1'b0;
    cyc(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      cyc(BIT_CLKS);
    end
    rx = d[3];
    cyc(16);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_busy_before: busy=%b, expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({rx_valid, frame_err, overrun, busy} !== 4'b0000 || rx_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL midrst_async: valid=%b fe=%b ov=%b busy=%b data=%h, expected all 0",
               rx_valid, frame_err, overrun, busy, rx_data);
    end
    rx = 1'b1;
    cyc(4);
    rst_n = 1'b1;
    cyc(40);
    tests_run++;
    if (rx_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_spurious: valid=%b busy=%b, expected 0 0", rx_valid, busy);
    end
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, BIT_CLKS, -1);
    cyc(4);
    tests_run++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin
      tests_failed++;
      $display("FAIL midrst_after: valid=%b data=%h, expected 1 5a", rx_valid, rx_data);
    end
    accept();
    check_drained("midrst");
  endtask

  initial begin
    rx       = 1'b1;
    rx_ready = 1'b0;
    rst_n    = 1'b0;
    cyc(1);
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    cyc(4);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Standalone oversampling UART receiver. It is the receiving end for the team's UART transmit path.
- Recovers 8N1-style frames from the asynchronous `rx` line using mid-bit majority voting and start-bit validation.
- Delivers each byte over a valid/ready handshake and flags framing and overrun errors.
- Sits between the board pin and any byte consumer (FIFO, command parser).

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line bit rate in bits/s.
- OVERSAMPLE, 16, sample ticks per bit; must be even and >= 8.
- DATA_BITS, 8, data bits per frame, sent LSB first; legal range 5..8.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; idles high.
- rx_data  output  DATA_BITS  received byte; valid while rx_valid=1.
- rx_valid  output  1  byte available; held until accepted.
- rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: frame completed while rx_valid still high.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release):
  - rx_data=0; rx_valid=0; frame_err=0; overrun=0; busy=0.
  - Synchronizer flops = 1; state=IDLE; all counters 0.
  - A reset mid-frame discards the partial frame.
- Synchronizer: 2-flop synchronizer on `rx`. All decoding uses the synchronized copy `rxs`, so `rx` edges reach `rxs` 2 cycles late.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer division, minimum 1.
  - Counter runs 0..DIV-1; `tick` pulses one cycle when count==DIV-1.
  - Counter is held at 0 in IDLE and starts counting on the cycle the start edge is detected.
- Sub-bit counter `os` runs 0..OVERSAMPLE-1 and advances on each tick.
  - Sample points are os = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - Bit value = majority of the 3 samples, decided on the tick at os=OVERSAMPLE/2+1.
- States:
  - IDLE:
    - rxs==0 -> START; clear os and bit index.
  - START:
    - At the decide point, bit==1 (false start/glitch) -> IDLE, no flags.
    - Otherwise continue to os=OVERSAMPLE-1 -> DATA.
  - DATA:
    - Shift the voted bit into the shift register LSB first.
    - After DATA_BITS bits (each ending at os=OVERSAMPLE-1) -> STOP.
  - STOP:
    - At the decide point, bit==1 -> deliver; bit==0 -> pulse frame_err and go to BRK.
    - Both paths leave STOP immediately at mid-bit, so a start bit directly after the stop bit is caught.
    - Delivery means: if rx_valid==0, load rx_data and set rx_valid.
  - BRK:
    - Wait for rxs==1, then IDLE. No start detection during BRK.
  - Undefined state encodings -> IDLE.
- Handshake:
  - rx_valid rises the cycle after the STOP decide tick.
  - rx_data is stable while rx_valid=1.
  - rx_valid & rx_ready clears rx_valid on the next edge.
- Overrun:
  - A delivery attempt while rx_valid=1 and rx_ready=0 pulses overrun.
  - The new byte is discarded; rx_data and rx_valid are unchanged.
- Simultaneous accept and delivery:
  - If rx_ready=1 in the same cycle a delivery occurs, the new byte is loaded and rx_valid stays 1.
  - No overrun in this case.
- frame_err and overrun never assert in the same cycle. A framing-error frame never sets rx_valid.

Test Plan:
Bench configuration: CLK_FREQ=32_000_000, BAUD=1_000_000, OVERSAMPLE=16, DATA_BITS=8, giving DIV=2 and one bit = 32 clocks.
1. Basic frame: send 0xA5 8N1, rx_ready=0 -> rx_valid rises and holds with rx_data=0xA5. Assert rx_ready for 1 cycle -> rx_valid=0 next cycle; frame_err=0, overrun=0.
2. Glitch rejection:
   - Drive rx low for 10 clocks, then high -> busy pulses, returns to IDLE, no rx_valid and no flags.
   - Then send 0x3C -> rx_data=0x3C.
   - Also: a 1-clock high spike in the middle of data bit 2 of 0x00 -> rx_data=0x00.
3. Framing error: send 0x81 with stop bit 0, hold rx low 5 bit times -> exactly one frame_err pulse, rx_valid stays 0, busy stays 1 until rx returns high. A following 0x7E is received correctly.
4. Overrun: send 0x11 and hold rx_ready=0; send 0x22 -> one overrun pulse, rx_data stays 0x11. Then accept -> rx_valid=0.
5. Back-to-back: rx_ready tied 1; send 0x00, 0xFF, 0x55 with zero idle between frames -> three rx_valid events carrying 0x00, 0xFF, 0x55 in order, no flags.
6. Reset mid-frame: pull rst_n low during data bit 3 -> all outputs 0 and busy=0 asynchronously. Release with rx idle high, send 0x5A -> rx_data=0x5A, no spurious valid from the aborted frame.
